// File: rtl/decoder_param_seq.sv
// Registered one-hot / thermometer / scan decoder with a valid/ready request port and a valid/ready beat port.
// A scan request streams one-hot beats from position I up to W-1, one per delivery.
module decoder_param_seq #(
    parameter  int N = 3,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] I,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready;
    // a beat transfers on a rising edge with out_valid && out_ready. in_ready never
    // depends on in_valid, and d/out_valid hold while out_valid && !out_ready.

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [N-1:0] LAST_POS = N'(W - 1);

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_pos, w_pos_nxt;
    logic [W-1:0] r_d, w_d_nxt;
    logic         r_out_valid, w_out_valid_nxt;

    logic         w_accept;
    logic         w_deliver;
    logic [N-1:0] w_pos_inc;
    logic [W-1:0] w_therm;
    logic [W-1:0] w_decoded;

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;
    assign w_pos_inc = r_pos + 1'b1;

    assign d         = r_d;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == SCAN);

    always_comb begin
        w_therm = '0;
        for (int k = 0; k < W; k++) begin
            w_therm[k] = (k <= int'(I));
        end
    end

    // Disabled and reserved requests still produce a (zero) beat.
    always_comb begin
        w_decoded = '0;
        if (en) begin
            case (mode)
                2'b00:   w_decoded = W'(1) << I;
                2'b01:   w_decoded = w_therm;
                2'b10:   w_decoded = W'(1) << I;
                default: w_decoded = '0;
            endcase
        end
    end

    // The final scan beat is presented from IDLE, so busy covers only the beats
    // that still have successors and a new request can be taken as it drains.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_d_nxt         = r_d;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_d_nxt         = w_decoded;
                    w_out_valid_nxt = 1'b1;
                    if (en && (mode == 2'b10) && (I != LAST_POS)) begin
                        w_state_nxt = SCAN;
                        w_pos_nxt   = I;
                    end
                end else if (w_deliver) begin
                    w_out_valid_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (w_deliver) begin
                    w_pos_nxt = w_pos_inc;
                    w_d_nxt   = W'(1) << w_pos_inc;
                    if (w_pos_inc == LAST_POS) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_d         <= w_d_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_param_seq.sv
// Self-checking bench for decoder_param_seq: directed scenarios plus randomized traffic,
// with expected beats queued at accept time and checked by an independent monitor.
module tb_decoder_param_seq;

    localparam int N = 3;
    localparam int W = 2**N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] I;
    logic         en;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;
    logic [W-1:0] exp_q[$];

    decoder_param_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (I),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the list of beats a request must produce, straight from the decode rules.
    function automatic void push_expected(input logic [N-1:0] i, input logic e, input logic [1:0] m);
        longint t;
        logic [63:0] v;
        if (!e || m == 2'b11) begin
            exp_q.push_back('0);
        end else if (m == 2'b00) begin
            t = longint'(1) << i;
            v = t;
            exp_q.push_back(v[W-1:0]);
        end else if (m == 2'b01) begin
            t = (longint'(1) << (int'(i) + 1)) - 1;
            v = t;
            exp_q.push_back(v[W-1:0]);
        end else begin
            for (int p = int'(i); p < W; p++) begin
                t = longint'(1) << p;
                v = t;
                exp_q.push_back(v[W-1:0]);
            end
        end
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [N-1:0] i, input logic e, input logic [1:0] m, input bit keep);
        int  n = 0;
        bit  done = 1'b0;
        bit  rdy;
        I = i; en = e; mode = m; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                push_expected(i, e, m);
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
                done = 1'b1;
            end
            #1;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: a beat is delivered at the next rising edge when both are high here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got d=%0h, required no beat", d);
            end else begin
                check("beat_d", 64'(d), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int wait_n;
        rst_n = 1'b0; in_valid = 1'b1; I = 3'd1; en = 1'b1; mode = 2'b00; out_ready = 1'b1;
        #1;
        check("rst_d", 64'(d), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("no_accept_in_reset", 64'(out_valid), 0);
        in_valid = 1'b0;
        step();
        check("idle_after_reset", 64'(out_valid), 0);

        // One-hot, I=5
        issue(3'd5, 1'b1, 2'b00, 1'b0);
        check("onehot_d", 64'(d), 64'h20);
        check("onehot_valid", 64'(out_valid), 1);
        step();
        check("onehot_drained", 64'(out_valid), 0);

        // Thermometer back-to-back
        issue(3'd0, 1'b1, 2'b01, 1'b1);
        check("therm0_d", 64'(d), 64'h01);
        check("therm0_in_ready", 64'(in_ready), 1);
        issue(3'd7, 1'b1, 2'b01, 1'b0);
        check("therm7_d", 64'(d), 64'hff);
        check("therm7_valid", 64'(out_valid), 1);
        step();

        // Scan from 5
        issue(3'd5, 1'b1, 2'b10, 1'b0);
        check("scan5_b0_d", 64'(d), 64'h20);
        check("scan5_b0_busy", 64'(busy), 1);
        check("scan5_b0_in_ready", 64'(in_ready), 0);
        step();
        check("scan5_b1_d", 64'(d), 64'h40);
        check("scan5_b1_busy", 64'(busy), 1);
        check("scan5_b1_in_ready", 64'(in_ready), 0);
        step();
        check("scan5_b2_d", 64'(d), 64'h80);
        check("scan5_b2_busy", 64'(busy), 0);
        check("scan5_b2_in_ready", 64'(in_ready), 1);
        step();
        check("scan5_done", 64'(out_valid), 0);

        // Backpressure hold
        out_ready = 1'b0;
        issue(3'd2, 1'b1, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("hold_d", 64'(d), 64'h04);
            check("hold_valid", 64'(out_valid), 1);
            check("hold_in_ready", 64'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("hold_released", 64'(out_valid), 0);

        // Disabled scan request
        issue(3'd1, 1'b0, 2'b10, 1'b0);
        check("en0_d", 64'(d), 0);
        check("en0_valid", 64'(out_valid), 1);
        check("en0_busy", 64'(busy), 0);
        step();
        check("en0_busy_after", 64'(busy), 0);
        check("en0_single_beat", 64'(out_valid), 0);

        // Reset mid-scan after the third beat
        issue(3'd0, 1'b1, 2'b10, 1'b0);
        repeat (3) step();
        check("midscan_d", 64'(d), 64'h08);
        rst_n = 1'b0;
        #1;
        check("abort_d", 64'(d), 0);
        check("abort_valid", 64'(out_valid), 0);
        check("abort_busy", 64'(busy), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) step();
        check("abort_no_beats", 64'(out_valid), 0);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 300; r++) begin
            issue(N'($urandom_range(0, W - 1)), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 200) begin
            step();
            wait_n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 0);
        step();
        check("final_idle_valid", 64'(out_valid), 0);
        check("final_idle_busy", 64'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
